// File: rtl/pet_bus_pkg.sv
// Shared definitions for the PET bus bridge.
// Holds the Pi memory-access FSM encoding, the default RAM strobe width and the
// SPI command-stage state encoding used by the command front end.
package pet_bus_pkg;

  // Default number of cycles a RAM strobe is held low (legal range 1..7).
  localparam int unsigned STROBE_CYCLES_DEFAULT = 2;

  // Pi memory-access FSM. These encodings appear on the debug state port.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitSlot = 3'd1,
    StSetup    = 3'd2,
    StStrobe   = 3'd3,
    StHold     = 3'd4,
    StDone     = 3'd5
  } pi_state_e;

  // SPI command-stage FSM.
  typedef enum logic [2:0] {
    SpiIdle     = 3'd0,
    SpiCmd      = 3'd1,
    SpiAddrHi   = 3'd2,
    SpiAddrLo   = 3'd3,
    SpiData     = 3'd4,
    SpiWaitDone = 3'd5
  } spi_state_e;

  // True in the states where the access owns the RAM bus.
  function automatic logic pi_state_owns_bus(input pi_state_e s);
    return (s == StSetup) || (s == StStrobe) || (s == StHold);
  endfunction

endpackage

// File: rtl/pi_mem_access.sv
// Pi-side RAM access sequencer.
// Accepts a level request from the SPI command stage, waits for a free CPU bus
// slot, then runs SETUP / STROBE / HOLD against the RAM and reports completion.
//
// Ports:
//   sys_clk, reset             clock, asynchronous active-high reset
//   pi_addr, pi_wr_data,       request address / write data / 1=read 0=write
//   pi_rw_b, pi_pending        pi_pending rising edge starts an access
//   pi_done, pi_rd_data        completion flag (held until pending drops), read data
//   pi_slot                    one-cycle strobe: bus free from the next cycle
//   ram_addr, ram_data_out,    RAM address, write data, data-bus drive enable
//   ram_data_oe, ram_data_in   and RAM read data
//   ram_oe_n, ram_we_n         active-low RAM strobes
//   state                      current FSM state for debug
module pi_mem_access
  import pet_bus_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = STROBE_CYCLES_DEFAULT,
  parameter int unsigned ADDR_WIDTH    = 17
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pi_addr,
  input  logic [7:0]            pi_wr_data,
  input  logic                  pi_rw_b,
  input  logic                  pi_pending,
  output logic                  pi_done,
  output logic [7:0]            pi_rd_data,
  input  logic                  pi_slot,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_data_out,
  output logic                  ram_data_oe,
  input  logic [7:0]            ram_data_in,
  output logic                  ram_oe_n,
  output logic                  ram_we_n,
  output logic [2:0]            state
);

  localparam logic [2:0] StrobeLast = 3'(STROBE_CYCLES - 1);

  pi_state_e             state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  pend_prev_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  rw_q, rw_d;
  logic                  done_q, done_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]            ram_data_out_q, ram_data_out_d;
  logic                  ram_data_oe_q, ram_data_oe_d;
  logic                  ram_oe_n_q, ram_oe_n_d;
  logic                  ram_we_n_q, ram_we_n_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rw_d           = rw_q;
    done_d         = done_q;
    rd_data_d      = rd_data_q;
    ram_addr_d     = ram_addr_q;
    ram_data_out_d = ram_data_out_q;

    case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (pi_pending && !pend_prev_q) begin
          addr_d  = pi_addr;
          wdata_d = pi_wr_data;
          rw_d    = pi_rw_b;
          state_d = StWaitSlot;
        end
      end
      StWaitSlot: begin
        if (!pi_pending) begin
          state_d = StIdle;
        end else if (pi_slot) begin
          // Address and write data are registered on entry so they are valid
          // for the whole SETUP cycle.
          state_d    = StSetup;
          ram_addr_d = addr_q;
          if (!rw_q) begin
            ram_data_out_d = wdata_q;
          end
        end
      end
      StSetup: begin
        state_d = StStrobe;
        cnt_d   = 3'd0;
      end
      StStrobe: begin
        // pi_pending is deliberately ignored here: a started strobe always completes.
        if (cnt_q == StrobeLast) begin
          state_d = StHold;
          if (rw_q) begin
            rd_data_d = ram_data_in;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHold: begin
        if (pi_pending) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      StDone: begin
        if (!pi_pending) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        done_d  = 1'b0;
      end
    endcase

    // Bus controls are registered from the next state so the strobes come
    // straight off flops and cannot glitch.
    ram_oe_n_d    = !((state_d == StStrobe) && rw_q);
    ram_we_n_d    = !((state_d == StStrobe) && !rw_q);
    ram_data_oe_d = pi_state_owns_bus(state_d) && !rw_q;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= 3'd0;
      pend_prev_q    <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= 8'h00;
      rw_q           <= 1'b1;
      done_q         <= 1'b0;
      rd_data_q      <= 8'h00;
      ram_addr_q     <= '0;
      ram_data_out_q <= 8'h00;
      ram_data_oe_q  <= 1'b0;
      ram_oe_n_q     <= 1'b1;
      ram_we_n_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pend_prev_q    <= pi_pending;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rw_q           <= rw_d;
      done_q         <= done_d;
      rd_data_q      <= rd_data_d;
      ram_addr_q     <= ram_addr_d;
      ram_data_out_q <= ram_data_out_d;
      ram_data_oe_q  <= ram_data_oe_d;
      ram_oe_n_q     <= ram_oe_n_d;
      ram_we_n_q     <= ram_we_n_d;
    end
  end

  assign pi_done      = done_q;
  assign pi_rd_data   = rd_data_q;
  assign ram_addr     = ram_addr_q;
  assign ram_data_out = ram_data_out_q;
  assign ram_data_oe  = ram_data_oe_q;
  assign ram_oe_n     = ram_oe_n_q;
  assign ram_we_n     = ram_we_n_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pi_mem_access.sv
// Directed and randomised self-checking bench for pi_mem_access.
module tb_pi_mem_access;

  logic        sys_clk;
  logic        reset;
  logic [16:0] pi_addr;
  logic [7:0]  pi_wr_data;
  logic        pi_rw_b;
  logic        pi_pending;
  logic        pi_done;
  logic [7:0]  pi_rd_data;
  logic        pi_slot;
  logic [16:0] ram_addr;
  logic [7:0]  ram_data_out;
  logic        ram_data_oe;
  logic [7:0]  ram_data_in;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  // RAM model: unwritten locations read back a fixed address-derived pattern.
  bit [7:0] ram_model   [0:131071];
  bit       ram_written [0:131071];
  logic     force_en  = 1'b0;
  logic [7:0] force_val = 8'h00;

  function automatic logic [7:0] init_val(input logic [16:0] a);
    return 8'h3C + a[7:0];
  endfunction

  assign ram_data_in = force_en ? force_val :
                       (ram_written[ram_addr] ? ram_model[ram_addr] : init_val(ram_addr));

  pi_mem_access #(
    .STROBE_CYCLES(2),
    .ADDR_WIDTH   (17)
  ) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .pi_addr     (pi_addr),
    .pi_wr_data  (pi_wr_data),
    .pi_rw_b     (pi_rw_b),
    .pi_pending  (pi_pending),
    .pi_done     (pi_done),
    .pi_rd_data  (pi_rd_data),
    .pi_slot     (pi_slot),
    .ram_addr    (ram_addr),
    .ram_data_out(ram_data_out),
    .ram_data_oe (ram_data_oe),
    .ram_data_in (ram_data_in),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n),
    .state       (state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Cumulative bus monitor, sampled on the falling edge.
  int   we_low_total    = 0;
  int   oe_low_total    = 0;
  int   overlap_total   = 0;
  int   doe_total       = 0;
  int   done_rise_total = 0;
  logic done_prev       = 1'b0;

  always @(negedge sys_clk) begin
    if (ram_we_n === 1'b0) we_low_total++;
    if (ram_oe_n === 1'b0) oe_low_total++;
    if (ram_we_n === 1'b0 && ram_oe_n === 1'b0) overlap_total++;
    if (ram_data_oe === 1'b1) doe_total++;
    if (pi_done === 1'b1 && done_prev === 1'b0) done_rise_total++;
    done_prev = pi_done;
    if (ram_we_n === 1'b0 && reset === 1'b0) begin
      ram_model[ram_addr]   = ram_data_out;
      ram_written[ram_addr] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("FAIL reset_state got=%0d want=0", state);
    end
    checks++;
    if ({pi_done, ram_oe_n, ram_we_n, ram_data_oe} !== 4'b0110) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0110", {pi_done, ram_oe_n, ram_we_n, ram_data_oe});
    end
    checks++;
    if (ram_addr !== 17'h0 || ram_data_out !== 8'h00 || pi_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_data got addr=%h dout=%h rd=%h want 0", ram_addr, ram_data_out,
               pi_rd_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write();
    int n;
    int we_cnt;
    int bad;
    int we0;
    int oe0;
    we0 = we_low_total;
    oe0 = oe_low_total;
    pi_addr = 17'h12345; pi_wr_data = 8'hA5; pi_rw_b = 1'b0; pi_pending = 1'b1;
    tick();
    checks++;
    if (state !== 3'd1) begin
      failures++; $display("FAIL wr_wait_state got=%0d want=1", state);
    end
    tick(); tick();
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    n = 1;
    checks++;
    if (state !== 3'd2 || ram_addr !== 17'h12345 || ram_data_oe !== 1'b1 || ram_we_n !== 1'b1)
    begin
      failures++;
      $display("FAIL wr_setup got st=%0d addr=%h oe=%b we_n=%b want 2/12345/1/1", state,
               ram_addr, ram_data_oe, ram_we_n);
    end
    we_cnt = 0; bad = 0;
    while (pi_done !== 1'b1 && n < 20) begin
      if (ram_we_n === 1'b0) begin
        we_cnt++;
        if (ram_addr !== 17'h12345 || ram_data_out !== 8'hA5 || ram_data_oe !== 1'b1) bad++;
      end
      if (n == 4 && (ram_we_n !== 1'b1 || ram_data_oe !== 1'b1 || ram_addr !== 17'h12345 ||
                     ram_data_out !== 8'hA5 || state !== 3'd4)) bad++;
      tick();
      n++;
    end
    checks++;
    if (n != 5) begin
      failures++; $display("FAIL wr_latency got=%0d want=5", n);
    end
    checks++;
    if (we_cnt != 2 || bad != 0) begin
      failures++; $display("FAIL wr_strobe got we_cycles=%0d bad=%0d want 2/0", we_cnt, bad);
    end
    pi_pending = 1'b0;
    tick();
    checks++;
    if (pi_done !== 1'b0 || state !== 3'd0 || ram_data_oe !== 1'b0) begin
      failures++;
      $display("FAIL wr_release got done=%b st=%0d doe=%b want 0/0/0", pi_done, state,
               ram_data_oe);
    end
    checks++;
    if (we_low_total - we0 != 2 || oe_low_total - oe0 != 0) begin
      failures++;
      $display("FAIL wr_monitor got we=%0d oe=%0d want 2/0", we_low_total - we0,
               oe_low_total - oe0);
    end
  endtask

  task automatic test_read();
    int n;
    int oe0;
    int we0;
    int doe0;
    oe0 = oe_low_total; we0 = we_low_total; doe0 = doe_total;
    pi_addr = 17'h08000; pi_wr_data = 8'h00; pi_rw_b = 1'b1; pi_pending = 1'b1;
    tick();
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    n = 1;
    while (pi_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (pi_done !== 1'b1 || pi_rd_data !== 8'h3C) begin
      failures++; $display("FAIL rd_data got done=%b rd=%h want 1/3c", pi_done, pi_rd_data);
    end
    checks++;
    if (oe_low_total - oe0 != 2 || we_low_total - we0 != 0 || doe_total - doe0 != 0) begin
      failures++;
      $display("FAIL rd_strobe got oe=%0d we=%0d doe=%0d want 2/0/0", oe_low_total - oe0,
               we_low_total - we0, doe_total - doe0);
    end
    force_en = 1'b1; force_val = 8'hFF;
    tick(); tick();
    checks++;
    if (pi_done !== 1'b1 || pi_rd_data !== 8'h3C || state !== 3'd5) begin
      failures++;
      $display("FAIL rd_hold got done=%b rd=%h st=%0d want 1/3c/5", pi_done, pi_rd_data, state);
    end
    force_en = 1'b0;
    pi_pending = 1'b0;
    tick();
    checks++;
    if (pi_done !== 1'b0 || state !== 3'd0) begin
      failures++; $display("FAIL rd_release got done=%b st=%0d want 0/0", pi_done, state);
    end
  endtask

  task automatic test_abandon_wait();
    int we0;
    int oe0;
    int dr0;
    we0 = we_low_total; oe0 = oe_low_total; dr0 = done_rise_total;
    pi_addr = 17'h00777; pi_wr_data = 8'h11; pi_rw_b = 1'b0; pi_pending = 1'b1;
    tick();
    pi_pending = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("FAIL abw_state got=%0d want=0", state);
    end
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    repeat (5) tick();
    checks++;
    if (we_low_total != we0 || oe_low_total != oe0 || done_rise_total != dr0 ||
        state !== 3'd0 || pi_done !== 1'b0) begin
      failures++;
      $display("FAIL abw_quiet got we=%0d oe=%0d done=%0d st=%0d want 0/0/0/0",
               we_low_total - we0, oe_low_total - oe0, done_rise_total - dr0, state);
    end
  endtask

  task automatic test_abandon_strobe();
    int we0;
    int dr0;
    we0 = we_low_total; dr0 = done_rise_total;
    pi_addr = 17'h00042; pi_wr_data = 8'h5A; pi_rw_b = 1'b0; pi_pending = 1'b1;
    tick();
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3 || ram_we_n !== 1'b0) begin
      failures++; $display("FAIL abs_first got st=%0d we_n=%b want 3/0", state, ram_we_n);
    end
    pi_pending = 1'b0;
    tick();
    tick();
    checks++;
    if (state !== 3'd4) begin
      failures++; $display("FAIL abs_hold got=%0d want=4", state);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("FAIL abs_idle got=%0d want=0", state);
    end
    repeat (3) tick();
    checks++;
    if (we_low_total - we0 != 2 || done_rise_total != dr0 || pi_done !== 1'b0) begin
      failures++;
      $display("FAIL abs_result got we=%0d done_rises=%0d want 2/0", we_low_total - we0,
               done_rise_total - dr0);
    end
  endtask

  task automatic test_slot_miss();
    int n;
    pi_addr = 17'h00100; pi_rw_b = 1'b1; pi_pending = 1'b1; pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      failures++; $display("FAIL miss_first got=%0d want=1", state);
    end
    tick();
    checks++;
    if (state !== 3'd1) begin
      failures++; $display("FAIL miss_wait got=%0d want=1", state);
    end
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    checks++;
    if (state !== 3'd2) begin
      failures++; $display("FAIL miss_setup got=%0d want=2", state);
    end
    n = 0;
    while (pi_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (pi_done !== 1'b1 || pi_rd_data !== init_val(17'h00100)) begin
      failures++;
      $display("FAIL miss_read got done=%b rd=%h want 1/%h", pi_done, pi_rd_data,
               init_val(17'h00100));
    end
    pi_pending = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_strobe();
    pi_addr = 17'h01234; pi_wr_data = 8'hC3; pi_rw_b = 1'b0; pi_pending = 1'b1;
    tick();
    pi_slot = 1'b1;
    tick();
    pi_slot = 1'b0;
    tick();
    checks++;
    if (ram_we_n !== 1'b0) begin
      failures++; $display("FAIL rst_pre got we_n=%b want 0", ram_we_n);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ram_we_n !== 1'b1 || ram_oe_n !== 1'b1 || ram_data_oe !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL rst_async got we_n=%b oe_n=%b doe=%b st=%0d want 1/1/0/0", ram_we_n,
               ram_oe_n, ram_data_oe, state);
    end
    checks++;
    if (ram_addr !== 17'h0 || ram_data_out !== 8'h00 || pi_done !== 1'b0 ||
        pi_rd_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_values got addr=%h dout=%h done=%b rd=%h want 0", ram_addr,
               ram_data_out, pi_done, pi_rd_data);
    end
    pi_pending = 1'b0;
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp_mem [0:15];
    int ov0;
    int dr0;
    int accepted;
    int n;
    logic [3:0] a;
    logic [7:0] d;
    logic rd;
    ov0 = overlap_total; dr0 = done_rise_total; accepted = 0;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(17'h00200 + 17'(i));
    for (int r = 0; r < 100; r++) begin
      a  = 4'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      pi_addr = 17'h00200 + 17'(a); pi_wr_data = d; pi_rw_b = rd; pi_pending = 1'b1;
      tick();
      accepted++;
      repeat ($urandom_range(0, 3)) tick();
      pi_slot = 1'b1;
      tick();
      pi_slot = 1'b0;
      repeat ($urandom_range(0, 4)) begin
        if (pi_done !== 1'b1) tick();
      end
      n = 0;
      while (pi_done !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      checks++;
      if (pi_done !== 1'b1) begin
        failures++; $display("FAIL rnd_timeout req=%0d", r);
      end else if (rd) begin
        checks++;
        if (pi_rd_data !== exp_mem[a]) begin
          failures++;
          $display("FAIL rnd_read req=%0d addr=%h got=%h want=%h", r, a, pi_rd_data, exp_mem[a]);
        end
      end else begin
        exp_mem[a] = d;
      end
      pi_pending = 1'b0;
      tick();
    end
    tick();
    checks++;
    if (overlap_total != ov0) begin
      failures++; $display("FAIL rnd_overlap got=%0d want=0", overlap_total - ov0);
    end
    checks++;
    if (done_rise_total - dr0 != accepted) begin
      failures++;
      $display("FAIL rnd_done_count got=%0d want=%0d", done_rise_total - dr0, accepted);
    end
  endtask

  initial begin
    reset = 1'b1; pi_addr = '0; pi_wr_data = 8'h00; pi_rw_b = 1'b1;
    pi_pending = 1'b0; pi_slot = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abandon_wait();
    test_abandon_strobe();
    test_slot_miss();
    test_reset_mid_strobe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
